// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master sending {addr,size,write} control word then write data or turnaround + read data.
// Optional SPI_MASTER_KEEP_SS_EN: a request accepted in the last HOLD cycle chains frames with ss_n held low.
package spi_pkg;
   localparam int AWIDTH = 8;
   localparam int DWIDTH = 32;
endpackage

module spi_master #(
   parameter int AWIDTH  = spi_pkg::AWIDTH,
   parameter int DWIDTH  = spi_pkg::DWIDTH,
   parameter int CLK_DIV = 2,
   parameter int SS_GAP  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode,
   input  logic              start,
   output logic              ready,
   input  logic              write,
   input  logic [1:0]        size,
   input  logic [AWIDTH-1:0] addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata,
   output logic              done,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   output logic              ss_n
);
   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_CTRL, S_WAIT, S_DATA_TX, S_DATA_RX, S_HOLD, S_GAP
   } state_t;

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int GAP_W = $clog2(SS_GAP + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SS_GAP - 1);
   localparam logic [5:0]        CTRL_LAST = 6'(AWIDTH + 2);
   localparam logic [AWIDTH+2:0] CTRL_ONE  = {{(AWIDTH+2){1'b0}}, 1'b1};
   localparam logic [DWIDTH-1:0] DATA_ONE  = {{(DWIDTH-1){1'b0}}, 1'b1};

   state_t              r_state, w_next_state;
   logic [DIV_W-1:0]    r_div;
   logic [GAP_W-1:0]    r_gap;
   logic [5:0]          r_cnt;
   logic                r_half;
   logic                r_cpol, r_cpha, r_write;
   logic [1:0]          r_size;
   logic [AWIDTH-1:0]   r_addr;
   logic [DWIDTH-1:0]   r_wdata, r_shift, r_rdata;
   logic                r_sck, r_mosi, r_ss_n, r_ready, r_done;

   logic                w_tick, w_bit_state, w_trail, w_bit_end, w_last_bit, w_next_bit;
   logic                w_accept, w_hold_end, w_gap_end, w_to_hold, w_rx_sample, w_div_run;
   logic [5:0]          w_cnt_inc, w_n_last;
   logic [AWIDTH+2:0]   w_ctrl;
   logic                w_ctrl_bit, w_wd_bit;

   assign w_tick      = (r_div == DIV_LAST);
   assign w_bit_state = (r_state == S_CTRL) || (r_state == S_WAIT) ||
                        (r_state == S_DATA_TX) || (r_state == S_DATA_RX);
   assign w_trail     = w_bit_state && w_tick && !r_half;
   assign w_bit_end   = w_bit_state && w_tick && r_half;
   assign w_div_run   = (r_state != S_IDLE) && (r_state != S_GAP);
   assign w_hold_end  = (r_state == S_HOLD) && w_tick;
   assign w_gap_end   = (r_state == S_GAP) && (r_gap == GAP_LAST);
   assign w_cnt_inc   = r_cnt + 6'd1;
   assign w_n_last    = (r_size == 2'd0) ? 6'd7 : (r_size == 2'd1) ? 6'd15 : 6'd31;
   assign w_ctrl      = {r_addr, r_size, r_write};
   assign w_ctrl_bit  = |(w_ctrl & (CTRL_ONE << w_cnt_inc));
   assign w_wd_bit    = |(r_wdata & (DATA_ONE << w_cnt_inc));
   assign w_to_hold   = w_bit_end && w_last_bit &&
                        ((r_state == S_DATA_TX) || (r_state == S_DATA_RX));
   // cpha=0 samples on the leading edge, which for RX bit 0 is the end of the WAIT bit
   assign w_rx_sample = r_cpha ? ((r_state == S_DATA_RX) && w_trail)
                               : (((r_state == S_WAIT) && w_bit_end) ||
                                  ((r_state == S_DATA_RX) && w_bit_end && !w_last_bit));

`ifdef SPI_MASTER_KEEP_SS_EN
   assign w_accept = start && ((r_state == S_IDLE) || w_hold_end);
`else
   assign w_accept = start && (r_state == S_IDLE);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_last_bit   = 1'b0;
      w_next_bit   = 1'b0;
      case (r_state)
         S_CTRL: begin
            w_last_bit = (r_cnt == CTRL_LAST);
            w_next_bit = w_last_bit ? (r_write & r_wdata[0]) : w_ctrl_bit;
         end
         S_WAIT:    w_last_bit = 1'b1;
         S_DATA_TX: begin
            w_last_bit = (r_cnt == w_n_last);
            w_next_bit = w_last_bit ? 1'b0 : w_wd_bit;
         end
         S_DATA_RX: w_last_bit = (r_cnt == w_n_last);
         default:   w_last_bit = 1'b0;
      endcase
      case (r_state)
         S_IDLE:    if (w_accept) w_next_state = S_SETUP;
         S_SETUP:   if (w_tick) w_next_state = S_CTRL;
         S_CTRL:    if (w_bit_end && w_last_bit) w_next_state = r_write ? S_DATA_TX : S_WAIT;
         S_WAIT:    if (w_bit_end) w_next_state = S_DATA_RX;
         S_DATA_TX,
         S_DATA_RX: if (w_to_hold) w_next_state = S_HOLD;
         S_HOLD:    if (w_tick) w_next_state = w_accept ? S_SETUP : S_GAP;
         S_GAP:     if (w_gap_end) w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div   <= '0;
         r_gap   <= '0;
         r_cnt   <= '0;
         r_half  <= 1'b0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_write <= 1'b0;
         r_size  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_shift <= '0;
         r_rdata <= '0;
         r_sck   <= 1'b0;
         r_mosi  <= 1'b0;
         r_ss_n  <= 1'b1;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_hold_end;
         r_gap  <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
         if (w_next_state != r_state) begin
            r_cnt <= '0;
         end else if (w_bit_end) begin
            r_cnt <= w_cnt_inc;
         end
         if (w_hold_end && !r_write) begin
            r_rdata <= r_shift;
         end
         if (w_accept) begin
            {r_cpol, r_cpha} <= mode;
            r_write <= write;
            r_size  <= size;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_div   <= '0;
            r_half  <= 1'b0;
            r_shift <= '0;
            r_ss_n  <= 1'b0;
            r_ready <= 1'b0;
            r_sck   <= mode[1];
            r_mosi  <= mode[0] ? 1'b0 : write;
         end else begin
            if (w_div_run) r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_bit_state && w_tick) r_half <= ~r_half;
            if (w_rx_sample) r_shift <= {r_shift[DWIDTH-2:0], miso};
            if (w_hold_end) r_ss_n <= 1'b1;
            if (w_gap_end) r_ready <= 1'b1;
            if ((r_state == S_SETUP) && w_tick) begin
               r_sck <= ~r_cpol;
            end else if (w_trail) begin
               r_sck <= r_cpol;
            end else if (w_bit_end && !w_to_hold) begin
               r_sck <= ~r_cpol;
            end
            if ((r_state == S_SETUP) && w_tick && r_cpha) begin
               r_mosi <= r_write;
            end else if ((w_trail && !r_cpha) || (w_bit_end && r_cpha)) begin
               r_mosi <= w_next_bit;
            end
         end
      end
   end

   assign ready = r_ready;
   assign done  = r_done;
   assign rdata = r_rdata;
   assign sck   = r_sck;
   assign mosi  = r_mosi;
   assign ss_n  = r_ss_n;
endmodule
